avr_sram_bridge: RTL and testbench
==================================

AVR_SRAM_BRIDGE -- requirements
Module: avr_sram_bridge

Interface
REQ-001 Parameter ADDR_W, default 21: SRAM address width and serial address shift register width.
REQ-002 Parameter DATA_W, default 8: data width of the AVR and SRAM data paths.
REQ-003 Parameter WAIT_CYCLES, default 2, legal range >= 1: SRAM strobe active length in clk cycles.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 avr_ce  in  1  1 = address-shift mode, 0 = data mode (all avr_* inputs are already synchronous to clk).
REQ-007 avr_clk  in  1  serial address shift clock, sampled by clk.
REQ-008 avr_si  in  1  serial address bit, MSB first.
REQ-009 avr_we  in  1  write strobe; a rising edge requests a write.
REQ-010 avr_oe  in  1  read strobe; a rising edge requests a read; the level enables avr_data_o.
REQ-011 avr_ctrl  in  3  [0] auto-step enable, [1] step direction (0 = +1, 1 = -1), [2] reserved and ignored.
REQ-012 avr_data_i  in  DATA_W  write data from the AVR.
REQ-013 avr_data_o  out  DATA_W  last read data, registered.
REQ-014 avr_data_oe  out  1  AVR data bus drive enable.
REQ-015 sram_addr  out  ADDR_W  current address register.
REQ-016 sram_data_i  in  DATA_W  SRAM read data.
REQ-017 sram_data_o  out  DATA_W  SRAM write data.
REQ-018 sram_data_oe  out  1  SRAM data bus drive enable.
REQ-019 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes, all registered.
REQ-020 busy  out  1  high while the access FSM is not IDLE.
REQ-021 ovr  out  1  sticky overrun flag.

Function
REQ-022 The block SHALL detect edges by comparing each of avr_clk, avr_we and avr_oe with a one-cycle registered copy; a rising edge is defined as current = 1 and previous = 0.
REQ-023 When avr_ce=1 and busy=0, each avr_clk rising edge SHALL perform sram_addr <= {sram_addr[ADDR_W-2:0], avr_si}; after ADDR_W edges the full address is loaded.
REQ-024 When avr_ce=0 or busy=1, avr_clk edges SHALL be ignored.
REQ-025 The FSM states SHALL be IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_WAIT and RD_DONE.
REQ-026 In IDLE with avr_ce=0, an avr_we rising edge SHALL latch avr_data_i into sram_data_o and go to WR_SETUP.
REQ-027 In IDLE with avr_ce=0, an avr_oe rising edge without a simultaneous avr_we rising edge SHALL go to RD_SETUP.
REQ-028 If avr_we and avr_oe rise in the same cycle, the write SHALL win and the read SHALL be dropped without setting ovr.
REQ-029 WR_SETUP SHALL last 1 cycle: sram_ce_n=0, sram_data_oe=1, sram_we_n=1.
REQ-030 WR_PULSE SHALL last WAIT_CYCLES cycles: sram_ce_n=0, sram_we_n=0, sram_data_oe=1.
REQ-031 WR_HOLD SHALL last 1 cycle: sram_we_n=1, sram_ce_n=0, sram_data_oe=1; the FSM then returns to IDLE.
REQ-032 RD_SETUP SHALL last 1 cycle: sram_ce_n=0, sram_oe_n=0.
REQ-033 RD_WAIT SHALL last WAIT_CYCLES cycles with the RD_SETUP strobes held; sram_data_i SHALL be captured into avr_data_o on the final RD_WAIT cycle.
REQ-034 RD_DONE SHALL last 1 cycle with all strobes high; the FSM then returns to IDLE.
REQ-035 An access SHALL hold busy for exactly WAIT_CYCLES+2 cycles.
REQ-036 sram_oe_n SHALL never be 0 while sram_data_oe=1.
REQ-037 During WR_HOLD and RD_DONE, if avr_ctrl[0]=1, sram_addr SHALL step by +1 or -1 per avr_ctrl[1], modulo 2^ADDR_W (all-ones +1 -> 0; 0 -1 -> all-ones).
REQ-038 A rising edge of avr_we or avr_oe while busy=1 SHALL be ignored and SHALL set ovr.
REQ-039 ovr SHALL be cleared on the first avr_clk rising edge accepted per REQ-023; a simultaneous set takes priority.
REQ-040 avr_data_oe SHALL equal avr_oe & ~avr_ce, registered (one-cycle latency).
REQ-041 avr_data_o SHALL hold its value until the next read capture.

Reset
REQ-042 On reset assertion, asynchronously: state=IDLE; sram_ce_n=sram_oe_n=sram_we_n=1; sram_data_oe=0; avr_data_oe=0; sram_addr=0; sram_data_o=0; avr_data_o=0; busy=0; ovr=0; edge-detect registers=0.
REQ-043 Reset asserted mid-access SHALL abort the access and release the strobes immediately, with no address step.

Verification (WAIT_CYCLES=2, ADDR_W=21, DATA_W=8)
REQ-044 Scenario: avr_ce=1, shift 21 bits of 0x1ABCDE MSB first -> sram_addr=0x1ABCDE, no SRAM strobe asserted.
REQ-045 Scenario: avr_ce=0, avr_data_i=0xA5, avr_ctrl=001, avr_we rises -> busy high 4 cycles, sram_we_n low exactly 2 cycles, sram_data_o=0xA5, sram_addr=0x1ABCDF afterwards.
REQ-046 Scenario: sram_addr=0, avr_ctrl=011, avr_oe rises, sram_data_i=0x3C -> avr_data_o=0x3C, sram_oe_n low 3 cycles, sram_addr=0x1FFFFF.
REQ-047 Scenario: avr_we and avr_oe rise in the same cycle -> write only, ovr=0; a further avr_oe edge during busy -> ignored, ovr=1, then cleared by the next shift edge.
REQ-048 Scenario: reset asserted in the second WR_PULSE cycle -> sram_we_n=1 and sram_ce_n=1 immediately, sram_addr=0, busy=0.

Source files
------------

// File: rtl/avr_sram_bridge.sv
// Bridges an AVR-style serial-address / parallel-data port onto an asynchronous SRAM.
// The address is shifted in serially and each strobe edge becomes one timed SRAM access.
module avr_sram_bridge #(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avr_ce,
  input  logic              avr_clk,
  input  logic              avr_si,
  input  logic              avr_we,
  input  logic              avr_oe,
  input  logic [2:0]        avr_ctrl,
  input  logic [DATA_W-1:0] avr_data_i,
  output logic [DATA_W-1:0] avr_data_o,
  output logic              avr_data_oe,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_data_i,
  output logic [DATA_W-1:0] sram_data_o,
  output logic              sram_data_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy,
  output logic              ovr
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_SETUP,
    RD_WAIT,
    RD_DONE
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             clk_q, we_q, oe_q;
  logic             clk_rise, we_rise, oe_rise;
  logic             cnt_last, shift_ok, step_ok;
  logic             ce_n_next, oe_n_next, we_n_next, data_oe_next;
  logic             unused_ctrl;

  assign unused_ctrl = avr_ctrl[2];

  assign clk_rise = avr_clk & ~clk_q;
  assign we_rise  = avr_we  & ~we_q;
  assign oe_rise  = avr_oe  & ~oe_q;
  assign cnt_last = (cnt == CNT_W'(WAIT_CYCLES - 1));
  assign shift_ok = avr_ce & ~busy & clk_rise;
  assign step_ok  = ((state == WR_HOLD) || (state == RD_DONE)) && avr_ctrl[0];

  // Strobes are decoded from the next state and registered, so they track the state exactly.
  always_comb begin
    // NOTE: every combinational output is assigned a default first so no path can infer a latch.
    state_next   = state;
    ce_n_next    = 1'b1;
    oe_n_next    = 1'b1;
    we_n_next    = 1'b1;
    data_oe_next = 1'b0;
    case (state)
      IDLE: begin
        if (!avr_ce) begin
          if (we_rise)      state_next = WR_SETUP;
          else if (oe_rise) state_next = RD_SETUP;
        end
      end
      WR_SETUP: state_next = WR_PULSE;
      WR_PULSE: if (cnt_last) state_next = WR_HOLD;
      WR_HOLD:  state_next = IDLE;
      RD_SETUP: state_next = RD_WAIT;
      RD_WAIT:  if (cnt_last) state_next = RD_DONE;
      RD_DONE:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    case (state_next)
      WR_SETUP, WR_HOLD: begin
        ce_n_next    = 1'b0;
        data_oe_next = 1'b1;
      end
      WR_PULSE: begin
        ce_n_next    = 1'b0;
        we_n_next    = 1'b0;
        data_oe_next = 1'b1;
      end
      RD_SETUP, RD_WAIT: begin
        ce_n_next = 1'b0;
        oe_n_next = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_data_oe <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= (state_next != state) ? '0 : cnt + CNT_W'(1);
      sram_ce_n    <= ce_n_next;
      sram_oe_n    <= oe_n_next;
      sram_we_n    <= we_n_next;
      sram_data_oe <= data_oe_next;
      busy         <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_q       <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      avr_data_oe <= 1'b0;
      avr_data_o  <= '0;
      sram_data_o <= '0;
      sram_addr   <= '0;
      ovr         <= 1'b0;
    end else begin
      clk_q       <= avr_clk;
      we_q        <= avr_we;
      oe_q        <= avr_oe;
      avr_data_oe <= avr_oe & ~avr_ce;

      if (state == IDLE && !avr_ce && we_rise)
        sram_data_o <= avr_data_i;
      if (state == RD_WAIT && cnt_last)
        avr_data_o <= sram_data_i;

      // Shifting only happens while idle and stepping only at the end of an access.
      if (shift_ok)
        sram_addr <= {sram_addr[ADDR_W-2:0], avr_si};
      else if (step_ok)
        sram_addr <= avr_ctrl[1] ? sram_addr - ADDR_W'(1) : sram_addr + ADDR_W'(1);

      if (busy && (we_rise || oe_rise))
        ovr <= 1'b1;
      else if (shift_ok)
        ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avr_sram_bridge.sv
// Self-checking bench for avr_sram_bridge: directed scenarios plus randomized accesses
// compared against a transaction-level model of the address, data and overrun state.
module tb_avr_sram_bridge;

  localparam int ADDR_W      = 21;
  localparam int DATA_W      = 8;
  localparam int WAIT_CYCLES = 2;
  localparam logic [31:0] AMASK = 32'h001F_FFFF;

  logic              clk = 1'b0;
  logic              reset;
  logic              avr_ce, avr_clk, avr_si, avr_we, avr_oe;
  logic [2:0]        avr_ctrl;
  logic [DATA_W-1:0] avr_data_i, avr_data_o, sram_data_i, sram_data_o;
  logic              avr_data_oe, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n, busy, ovr;
  logic [ADDR_W-1:0] sram_addr;

  avr_sram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .avr_ce(avr_ce), .avr_clk(avr_clk), .avr_si(avr_si), .avr_we(avr_we), .avr_oe(avr_oe),
    .avr_ctrl(avr_ctrl), .avr_data_i(avr_data_i), .avr_data_o(avr_data_o),
    .avr_data_oe(avr_data_oe), .sram_addr(sram_addr), .sram_data_i(sram_data_i),
    .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .busy(busy), .ovr(ovr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what the AVR side should see after each transaction.
  logic [31:0] m_addr;
  logic [7:0]  m_wr, m_rd;
  logic        m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] stepped(input logic [31:0] a, input logic [2:0] c);
    if (!c[0]) return a;
    if (c[1])  return (a + AMASK) & AMASK;
    return (a + 32'd1) & AMASK;
  endfunction

  task automatic shift_in(input logic [31:0] val);
    int strobe_low = 0;
    avr_ce = 1'b1;
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      avr_si  = val[i];
      avr_clk = 1'b1;
      tick();
      if (!sram_ce_n || !sram_oe_n || !sram_we_n) strobe_low++;
      avr_clk = 1'b0;
      tick();
      if (!sram_ce_n || !sram_oe_n || !sram_we_n) strobe_low++;
    end
    m_addr = val & AMASK;
    m_ovr  = 1'b0;
    check("shift_addr", sram_addr, m_addr);
    check("shift_strobes", strobe_low, 0);
    check("shift_ovr", ovr, m_ovr);
  endtask

  // One access; 'both' raises avr_oe with avr_we, 'disturb' adds an oe edge and an
  // avr_clk edge while the access is in flight.
  task automatic access(input bit is_read, input logic [7:0] data, input logic [2:0] ctrl,
                        input bit both, input bit disturb);
    int busy_n = 0, we_low = 0, oe_low = 0, clash = 0;
    avr_ce      = 1'b0;
    avr_ctrl    = ctrl;
    avr_data_i  = is_read ? 8'($urandom) : data;
    sram_data_i = is_read ? data : 8'($urandom);
    tick();
    if (is_read) avr_oe = 1'b1;
    else         avr_we = 1'b1;
    if (both)    avr_oe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy)       busy_n++;
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if (!sram_oe_n && sram_data_oe) clash++;
      avr_we = 1'b0;
      if (disturb && i == 1) avr_oe = 1'b1;
      if (disturb && i == 2) begin avr_ce = 1'b1; avr_si = 1'b1; avr_clk = 1'b1; end
      if (disturb && i == 3) begin avr_ce = 1'b0; avr_clk = 1'b0; end
    end
    if (is_read) m_rd = data;
    else         m_wr = data;
    m_addr = stepped(m_addr, ctrl);
    if (disturb) m_ovr = 1'b1;
    check("busy_cycles", busy_n, WAIT_CYCLES + 2);
    check("we_n_low_cycles", we_low, is_read ? 0 : WAIT_CYCLES);
    check("oe_n_low_cycles", oe_low, is_read ? WAIT_CYCLES + 1 : 0);
    check("oe_vs_data_oe", clash, 0);
    check("sram_data_o", sram_data_o, m_wr);
    check("avr_data_o", avr_data_o, m_rd);
    check("addr_after", sram_addr, m_addr);
    check("ovr_after", ovr, m_ovr);
    check("avr_data_oe_on", avr_data_oe, is_read || both || disturb);
    avr_oe = 1'b0;
    tick();
    check("avr_data_oe_off", avr_data_oe, 1'b0);
  endtask

  initial begin
    int busy_n;
    reset = 1'b1;
    {avr_ce, avr_clk, avr_si, avr_we, avr_oe} = '0;
    avr_ctrl = '0; avr_data_i = '0; sram_data_i = '0;
    m_addr = 0; m_wr = 0; m_rd = 0; m_ovr = 0;
    tick(); tick();
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 4'b1110);
    check("rst_busy_ovr", {busy, ovr, avr_data_oe}, 3'b000);
    check("rst_addr", sram_addr, 0);
    check("rst_data", {sram_data_o, avr_data_o}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    tick();

    shift_in(32'h1ABCDE);
    access(1'b0, 8'hA5, 3'b001, 1'b0, 1'b0);
    check("write_step_addr", sram_addr, 32'h1ABCDF);

    shift_in(32'h0);
    access(1'b1, 8'h3C, 3'b011, 1'b0, 1'b0);
    check("read_wrap_down", sram_addr, 32'h1FFFFF);

    access(1'b0, 8'h5A, 3'b101, 1'b0, 1'b0);
    check("write_wrap_up", sram_addr, 32'h0);

    shift_in(32'h0F0F0F);
    access(1'b0, 8'h77, 3'b000, 1'b1, 1'b0);
    check("same_cycle_no_ovr", ovr, 1'b0);

    access(1'b0, 8'h11, 3'b001, 1'b0, 1'b1);
    check("ovr_set", ovr, 1'b1);
    avr_ce = 1'b1; avr_si = 1'b1; avr_clk = 1'b1;
    tick();
    avr_clk = 1'b0;
    tick();
    m_addr = ((m_addr << 1) | 32'd1) & AMASK;
    m_ovr  = 1'b0;
    check("ovr_cleared", ovr, m_ovr);
    check("ovr_clear_addr", sram_addr, m_addr);

    avr_ce = 1'b1; avr_we = 1'b1; avr_oe = 1'b1;
    busy_n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy) busy_n++;
    end
    avr_we = 1'b0; avr_oe = 1'b0;
    check("ce_blocks_access", busy_n, 0);

    for (int n = 0; n < 8; n++) begin
      shift_in($urandom & AMASK);
      access(1'($urandom), 8'($urandom), 3'($urandom), 1'b0, 1'b0);
    end

    shift_in(32'h12345);
    avr_ce = 1'b0; avr_ctrl = 3'b001; avr_data_i = 8'hC3;
    tick();
    avr_we = 1'b1;
    tick();
    avr_we = 1'b0;
    tick(); tick();
    check("pre_reset_we_n", sram_we_n, 1'b0);
    reset = 1'b1;
    #1;
    check("abort_strobes", {sram_we_n, sram_ce_n}, 2'b11);
    check("abort_addr", sram_addr, 0);
    check("abort_busy", busy, 1'b0);
    check("abort_data", {avr_data_o, sram_data_o}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
